div_iter_ctrl: RTL and testbench
================================

Name: div_iter_ctrl

Overview:
- Sequencing controller for an iterative radix-2 restoring divider. It replaces the single-cycle combinational divide/remainder path in the execute stage.
- Accepts one DIV/DIVU/REM/REMU request at a time from execute and runs the shared quotient/remainder datapath for XLEN iterations.
- Applies RISC-V sign fix-up and special cases, then holds the result until the downstream stage accepts it.
- Execute uses busy/resp_valid to drive its ready_go stall. A flush from branch misprediction or trap redirect aborts the operation in flight.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- TAG_W, 5, width of the opaque tag (destination rd) carried from request to response.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  execute presents a divide request
- req_ready  output  1  controller can accept a request this cycle
- req_op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
- req_a  input  XLEN  dividend (rs1)
- req_b  input  XLEN  divisor (rs2)
- req_tag  input  TAG_W  tag, returned unchanged
- flush  input  1  abort any in-flight operation
- resp_valid  output  1  result available
- resp_ready  input  1  downstream accepts the result
- resp_data  output  XLEN  quotient or remainder, selected by the latched op
- resp_tag  output  TAG_W  latched req_tag
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, iteration counter=0.
  - req_ready=1 after reset; resp_valid=0, resp_data=0, resp_tag=0, busy=0.
  - Reset in any state aborts the operation with no response.
- States: IDLE, CALC, FIXUP, DONE.
- Handshakes:
  - Accept = req_valid && req_ready.
  - req_ready = (state==IDLE) && !flush. No request is accepted in any other state, so there is no back-to-back acceptance from DONE.
- IDLE, on accept:
  - Latch op, tag, sign flags, and the signed/unsigned interpretation (signed for DIV and REM).
  - If req_b==0: next state is DONE, with quotient=all-ones and remainder=req_a.
  - Else if signed, req_a==0x80000000 and req_b==all-ones: next state is DONE, with quotient=0x80000000 and remainder=0.
  - Otherwise: load the magnitudes |a| and |b| (raw values for unsigned ops), clear the partial remainder, set counter=XLEN-1, and go to CALC.
- CALC, one quotient bit per cycle:
  - Shift {rem, quot} left by 1, shifting in the dividend MSB.
  - Trial subtraction uses an XLEN+1-bit difference. If non-negative, keep the difference and set quot[0]=1.
  - At counter==0, go to FIXUP; otherwise decrement the counter. CALC therefore lasts exactly XLEN cycles.
- FIXUP:
  - Negate the quotient if signed and the sign of a differs from the sign of b.
  - Negate the remainder if signed and a is negative.
  - Go to DONE.
- DONE:
  - resp_valid=1.
  - resp_data = quotient for DIV/DIVU, remainder for REM/REMU.
  - resp_data and resp_tag stay stable while resp_valid=1 and resp_ready=0.
  - On resp_valid && resp_ready, go to IDLE; resp_valid drops the next cycle.
- Latency, counted from the accept edge:
  - Normal path: resp_valid rises after XLEN+2 edges (34 for XLEN=32).
  - Special cases: resp_valid rises after 1 edge.
- Flush:
  - flush=1 at an edge forces IDLE from any state and clears resp_valid.
  - Flush takes priority over accept and over response acceptance in the same cycle. If resp_ready and flush coincide in DONE, the result is treated as consumed and dropped.
- busy=1 in CALC, FIXUP and DONE.
- All arithmetic is modulo 2^XLEN; negation is two's complement. Negating 0x80000000 yields 0x80000000, which the unsigned magnitude interpretation handles.

Test Plan:
- DIVU a=100, b=7, tag=3 -> resp_data=14, resp_tag=3; resp_valid first high 34 cycles after the accept edge. Repeat as REMU -> 2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. REM a=7, b=-2 -> 1.
- DIVU/REMU with b=0, a=0x1234 -> 0xFFFFFFFF and 0x1234 respectively, each with resp_valid one edge after accept. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid, resp_data and resp_tag stay stable, req_ready=0 and busy=1. Then assert resp_ready -> IDLE, with req_ready=1 the next cycle.
- Flush 10 cycles into CALC -> IDLE next edge, no resp_valid. Flush asserted together with req_valid in IDLE -> request not accepted. A new request afterwards completes correctly: DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- rst asserted in FIXUP -> all outputs return to reset values. A random signed/unsigned sweep of 1000 operand pairs must match the reference RISC-V semantics model.

Source files
------------

// File: rtl/div_iter_ctrl.sv
// Sequencing controller for an iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
// One quotient bit per cycle, RISC-V sign fix-up and special cases, result held until accepted.
module div_iter_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  // Handshake: a request transfers on a clock edge where req_valid && req_ready,
  // a response transfers where resp_valid && resp_ready; flush overrides both.

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic             sel_rem_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic [XLEN-1:0]  quot_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  divisor_q;
  logic [CNT_W-1:0] cnt_q;

  logic            accept;
  logic            req_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_by_zero;
  logic            overflow;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;

  always_comb begin
    req_signed  = !req_op[0];
    a_neg       = req_signed && req_a[XLEN-1];
    b_neg       = req_signed && req_b[XLEN-1];
    div_by_zero = (req_b == '0);
    overflow    = req_signed && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
    abs_a       = a_neg ? (-req_a) : req_a;
    abs_b       = b_neg ? (-req_b) : req_b;
    accept      = req_valid && req_ready;
  end

  // Partial remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor_q};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (div_by_zero || overflow) state_next = DONE;
          else                         state_next = CALC;
        end
      end
      CALC:    if (cnt_q == '0) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_rem_q  <= 1'b0;
      tag_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            sel_rem_q  <= req_op[1];
            tag_q      <= req_tag;
            neg_quot_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            if (div_by_zero) begin
              quot_q <= '1;
              rem_q  <= req_a;
            end else if (overflow) begin
              quot_q <= {1'b1, {(XLEN-1){1'b0}}};
              rem_q  <= '0;
            end else begin
              quot_q    <= abs_a;
              rem_q     <= '0;
              divisor_q <= abs_b;
              cnt_q     <= CNT_W'(XLEN-1);
            end
          end
        end
        CALC: begin
          if (!diff[XLEN]) begin
            rem_q  <= diff[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q  <= rem_shift[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        FIXUP: begin
          if (neg_quot_q) quot_q <= -quot_q;
          if (neg_rem_q)  rem_q  <= -rem_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE) && !flush;
    busy       = (state != IDLE);
    resp_valid = (state == DONE);
    resp_data  = (state == DONE) ? (sel_rem_q ? rem_q : quot_q) : '0;
    resp_tag   = tag_q;
  end

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Bench for div_iter_ctrl: directed vector table, multi-cycle corner sequences,
// and a random sweep checked against a RISC-V division reference model.
module tb_div_iter_ctrl;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  int checks;
  int failures;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [1:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp;
    int               lat;
  } vec_t;

  vec_t vecs[14];

  div_iter_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic signed [XLEN-1:0] sr;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sr = sa / sb;
        return sr;
      end
      2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sr = sa % sb;
        return sr;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: issue one request; the accept edge counts as latency 1
  task automatic send_req(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAG_W-1:0] tag);
    @(negedge clk);
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cycles);
    cycles = 1;
    while (!resp_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_valid_after_consume", {31'b0, resp_valid}, 32'd0);
    check("req_ready_after_consume", {31'b0, req_ready}, 32'd1);
  endtask

  // full transaction; expected data comes from the scoreboard queue
  task automatic run_req(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag, input int lat);
    int cyc;
    logic [XLEN-1:0] exp;
    send_req(op, a, b, tag);
    wait_resp(cyc);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({name, "_latency"}, cyc, lat);
    check({name, "_data"}, resp_data, exp);
    check({name, "_tag"}, {27'b0, resp_tag}, {27'b0, tag});
    consume();
  endtask

  initial begin
    int cyc;
    logic [XLEN-1:0] held_data;
    logic [TAG_W-1:0] held_tag;
    bit saw_valid;

    checks = 0; failures = 0;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; req_tag = '0;
    flush = 1'b0; resp_ready = 1'b0;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          5'd3,  32'd14,         34};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          5'd4,  32'd2,          34};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD,  34};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  34};
    vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd7,  32'd1,          34};
    vecs[5]  = '{2'b01, 32'h1234,       32'd0,          5'd8,  32'hFFFF_FFFF,  1};
    vecs[6]  = '{2'b11, 32'h1234,       32'd0,          5'd9,  32'h1234,       1};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  1};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          1};
    vecs[9]  = '{2'b00, 32'h1234,       32'd0,          5'd12, 32'hFFFF_FFFF,  1};
    vecs[10] = '{2'b00, 32'h8000_0000,  32'd1,          5'd13, 32'h8000_0000,  34};
    vecs[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          34};
    vecs[12] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd15, 32'hFFFF_FFFE,  34};
    vecs[13] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd31, 32'd14,         34};

    apply_reset();
    #1;
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset_resp_data", resp_data, 32'd0);
    check("reset_resp_tag", {27'b0, resp_tag}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(vecs[i].exp);
      run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].lat);
    end

    // backpressure in DONE
    send_req(2'b01, 32'd100, 32'd7, 5'd21);
    wait_resp(cyc);
    check("bp_latency", cyc, 34);
    held_data = resp_data;
    held_tag  = resp_tag;
    check("bp_data", held_data, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold", {resp_valid, req_ready, busy, 24'b0, resp_data == held_data, resp_tag == held_tag, 3'b0},
            {1'b1, 1'b0, 1'b1, 24'b0, 1'b1, 1'b1, 3'b0});
    end
    consume();

    // flush 10 cycles into CALC
    send_req(2'b01, 32'd1000, 32'd3, 5'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_calc_busy", {31'b0, busy}, 32'd0);
    check("flush_calc_req_ready_during", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_calc_req_ready_after", {31'b0, req_ready}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) saw_valid = 1'b1;
    end
    check("flush_calc_no_resp", {31'b0, saw_valid}, 32'd0);

    // flush together with a request in IDLE
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd50; req_b = 32'd5; req_tag = 5'd2;
    flush = 1'b1;
    #1;
    check("flush_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush = 1'b0;
    check("flush_req_not_accepted", {31'b0, busy}, 32'd0);
    exp_q.push_back(32'hFFFF_FFFF);
    run_req("post_flush", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd17, 34);

    // flush and resp_ready together in DONE: result dropped
    send_req(2'b01, 32'h55, 32'd0, 5'd18);
    #1;
    check("flush_done_valid", {31'b0, resp_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; resp_ready = 1'b0;
    check("flush_done_idle", {30'b0, busy, resp_valid}, 32'd0);

    // reset while in FIXUP: state is FIXUP after 33 edges from accept
    send_req(2'b00, 32'd12345, 32'd67, 5'd19);
    repeat (32) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_fixup_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_fixup_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_fixup_resp_data", resp_data, 32'd0);
    check("rst_fixup_resp_tag", {27'b0, resp_tag}, 32'd0);
    check("rst_fixup_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) saw_valid = 1'b1;
    end
    check("rst_fixup_no_resp", {31'b0, saw_valid}, 32'd0);

    // random sweep
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      int sel;
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 20));
      else if (sel == 3) b = -32'($urandom_range(1, 20));
      else if (sel == 4) a = 32'($urandom_range(0, 100));
      exp_q.push_back(ref_model(op, a, b));
      run_req("rand", op, a, b, 5'($urandom_range(0, 31)), ref_lat(op, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
